// File: rtl/adder_n_if.sv
// rtl/adder_n_if.sv - operand/result bundle for adder_n_core
interface adder_n_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, a, b, cin,
      input  out_valid, sum, cout, ovf, zero
   );

   modport slave (
      input  in_valid, a, b, cin,
      output out_valid, sum, cout, ovf, zero
   );
endinterface

// File: rtl/adder_n_core.sv
// rtl/adder_n_core.sv - registered a+b+cin adder, 1 or 2 stages; ADDER_N_SAT_EN enables unsigned saturation
module adder_n_core #(
   parameter int WIDTH       = 8,
   parameter int PIPE_STAGES = 1
) (
   input  logic      clk,
   input  logic      rst,
   adder_n_if.slave  bus
);
   // Final-stage inputs: full WIDTH+1 result plus operand sign bits for ovf.
   logic             fin_valid;
   logic [WIDTH:0]   fin_res;
   logic             fin_a_msb;
   logic             fin_b_msb;

   generate
      if (PIPE_STAGES == 2) begin : g_pipe2
         localparam int LO = (WIDTH / 2 < 1) ? 1 : WIDTH / 2;

         logic             s1_valid_q, s1_valid_d;
         logic [LO-1:0]    s1_lo_q, s1_lo_d;
         logic             s1_c_q, s1_c_d;
         logic [WIDTH-1:0] s1_a_hi_q, s1_a_hi_d;
         logic [WIDTH-1:0] s1_b_hi_q, s1_b_hi_d;
         logic             s1_a_msb_q, s1_a_msb_d;
         logic             s1_b_msb_q, s1_b_msb_d;
         logic [LO:0]      lo_add;
         logic [WIDTH:0]   hi_add;

         always_comb begin
            lo_add     = {1'b0, bus.a[LO-1:0]} + {1'b0, bus.b[LO-1:0]} + {{LO{1'b0}}, bus.cin};
            s1_valid_d = bus.in_valid;
            s1_lo_d    = s1_lo_q;
            s1_c_d     = s1_c_q;
            s1_a_hi_d  = s1_a_hi_q;
            s1_b_hi_d  = s1_b_hi_q;
            s1_a_msb_d = s1_a_msb_q;
            s1_b_msb_d = s1_b_msb_q;
            if (bus.in_valid) begin
               s1_lo_d    = lo_add[LO-1:0];
               s1_c_d     = lo_add[LO];
               s1_a_hi_d  = bus.a >> LO;
               s1_b_hi_d  = bus.b >> LO;
               s1_a_msb_d = bus.a[WIDTH-1];
               s1_b_msb_d = bus.b[WIDTH-1];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               s1_valid_q <= 1'b0;
               s1_lo_q    <= '0;
               s1_c_q     <= 1'b0;
               s1_a_hi_q  <= '0;
               s1_b_hi_q  <= '0;
               s1_a_msb_q <= 1'b0;
               s1_b_msb_q <= 1'b0;
            end else begin
               s1_valid_q <= s1_valid_d;
               s1_lo_q    <= s1_lo_d;
               s1_c_q     <= s1_c_d;
               s1_a_hi_q  <= s1_a_hi_d;
               s1_b_hi_q  <= s1_b_hi_d;
               s1_a_msb_q <= s1_a_msb_d;
               s1_b_msb_q <= s1_b_msb_d;
            end
         end

         // Upper halves are kept right-aligned so WIDTH=1 (empty upper half) needs no special case.
         always_comb begin
            hi_add    = {1'b0, s1_a_hi_q} + {1'b0, s1_b_hi_q} + {{WIDTH{1'b0}}, s1_c_q};
            fin_valid = s1_valid_q;
            fin_res   = (hi_add << LO) | {{(WIDTH - LO + 1){1'b0}}, s1_lo_q};
            fin_a_msb = s1_a_msb_q;
            fin_b_msb = s1_b_msb_q;
         end
      end else begin : g_pipe1
         always_comb begin
            fin_valid = bus.in_valid;
            fin_res   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
            fin_a_msb = bus.a[WIDTH-1];
            fin_b_msb = bus.b[WIDTH-1];
         end
      end
   endgenerate

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] raw_sum;
   logic [WIDTH-1:0] res_sum;

   always_comb begin
      raw_sum = fin_res[WIDTH-1:0];
`ifdef ADDER_N_SAT_EN
      res_sum = fin_res[WIDTH] ? {WIDTH{1'b1}} : raw_sum;
`else
      res_sum = raw_sum;
`endif
      out_valid_d = fin_valid;
      sum_d       = sum_q;
      cout_d      = cout_q;
      ovf_d       = ovf_q;
      zero_d      = zero_q;
      if (fin_valid) begin
         sum_d  = res_sum;
         cout_d = fin_res[WIDTH];
         ovf_d  = (fin_a_msb == fin_b_msb) && (raw_sum[WIDTH-1] != fin_a_msb);
         zero_d = (res_sum == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
         zero_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
         ovf_q       <= ovf_d;
         zero_q      <= zero_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule

// File: tb/tb_adder_n_core.sv
// tb/tb_adder_n_core.sv - directed and random checks of adder_n_core (W8 P1, W8 P2, W1 P2)
module tb_adder_n_core;
   logic clk;
   logic rst;

   adder_n_if #(.WIDTH(8)) if8a ();
   adder_n_if #(.WIDTH(8)) if8b ();
   adder_n_if #(.WIDTH(1)) if1 ();

   adder_n_core #(.WIDTH(8), .PIPE_STAGES(1)) u8p1 (.clk(clk), .rst(rst), .bus(if8a));
   adder_n_core #(.WIDTH(8), .PIPE_STAGES(2)) u8p2 (.clk(clk), .rst(rst), .bus(if8b));
   adder_n_core #(.WIDTH(1), .PIPE_STAGES(2)) u1p2 (.clk(clk), .rst(rst), .bus(if1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {out_valid, zero, ovf, cout, sum}
   logic [11:0] obs1, obs2, obs0;
   assign obs1 = {if8a.out_valid, if8a.zero, if8a.ovf, if8a.cout, if8a.sum};
   assign obs2 = {if8b.out_valid, if8b.zero, if8b.ovf, if8b.cout, if8b.sum};
   assign obs0 = {7'd0, if1.out_valid, if1.zero, if1.ovf, if1.cout, if1.sum};

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [11:0] observed, input logic [11:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("FAIL %s observed=%03h expected=%03h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
      if8a.in_valid = v; if8a.a = a; if8a.b = b; if8a.cin = c;
      if8b.in_valid = v; if8b.a = a; if8b.b = b; if8b.cin = c;
   endtask

   // Reference: {zero, ovf, cout, sum}; ovf from the raw sum, zero from the delivered sum.
   function automatic logic [10:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
      logic [8:0] t;
      logic [7:0] s;
      logic       o;
      t = {1'b0, a} + {1'b0, b} + {8'd0, c};
      s = t[7:0];
      o = (a[7] == b[7]) && (s[7] != a[7]);
`ifdef ADDER_N_SAT_EN
      if (t[8]) s = 8'hFF;
`endif
      return {(s == 8'd0), o, t[8], s};
   endfunction

   task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                       input logic [11:0] exp);
      drive8(1'b1, a, b, c);
      tick();
      drive8(1'b0, 8'd0, 8'd0, 1'b0);
      chk({tag, "_p1"}, obs1, exp);
      chk({tag, "_p2_early"}, {11'd0, if8b.out_valid}, 12'd0);
      tick();
      chk({tag, "_p2"}, obs2, exp);
      chk({tag, "_p1_hold"}, obs1, exp & 12'h7FF);
   endtask

   task automatic dir1(input string tag, input logic a, input logic b, input logic c,
                       input logic [11:0] exp);
      if1.in_valid = 1'b1; if1.a = a; if1.b = b; if1.cin = c;
      tick();
      if1.in_valid = 1'b0;
      chk({tag, "_early"}, {11'd0, if1.out_valid}, 12'd0);
      tick();
      chk(tag, obs0, exp);
   endtask

   logic        pv1, pv2, v;
   logic [10:0] pr1, pr2, hold1, hold2;
   logic [7:0]  ra, rb;
   logic        rc;
   int          accepted, nout1, nout2;

   initial begin
      rst = 1'b1;
      drive8(1'b0, 8'd0, 8'd0, 1'b0);
      if1.in_valid = 1'b0; if1.a = 1'b0; if1.b = 1'b0; if1.cin = 1'b0;
      tick(); tick(); tick();
      chk("reset_p1", obs1, 12'h000);
      chk("reset_p2", obs2, 12'h000);
      chk("reset_w1", obs0, 12'h000);
      rst = 1'b0;

      dir8("add_3_5", 8'h03, 8'h05, 1'b0, 12'h808);
`ifdef ADDER_N_SAT_EN
      dir8("ff_plus_1", 8'hFF, 8'h01, 1'b0, 12'h9FF);
      dir8("80_plus_80", 8'h80, 8'h80, 1'b0, 12'hBFF);
`else
      dir8("ff_plus_1", 8'hFF, 8'h01, 1'b0, 12'hD00);
      dir8("80_plus_80", 8'h80, 8'h80, 1'b0, 12'hF00);
`endif
      dir8("7f_plus_1", 8'h7F, 8'h01, 1'b0, 12'hA80);
      dir8("ff_ff_cin", 8'hFF, 8'hFF, 1'b1, 12'h9FF);
      dir8("cin_only", 8'h00, 8'h00, 1'b1, 12'h801);

      dir1("w1_111", 1'b1, 1'b1, 1'b1, 12'h013);
      dir1("w1_100", 1'b1, 1'b0, 1'b0, 12'h011);
`ifdef ADDER_N_SAT_EN
      dir1("w1_110", 1'b1, 1'b1, 1'b0, 12'h017);
`else
      dir1("w1_110", 1'b1, 1'b1, 1'b0, 12'h01E);
`endif

      // Two accepted operands, reset on the edge that takes the second one.
      drive8(1'b1, 8'h11, 8'h22, 1'b0);
      tick();
      chk("rst_mid_s1", {11'd0, if8b.out_valid}, 12'd0);
      drive8(1'b1, 8'h33, 8'h44, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive8(1'b0, 8'd0, 8'd0, 1'b0);
      chk("rst_mid_p2_zero", obs2, 12'h000);
      chk("rst_mid_p1_zero", obs1, 12'h000);
      tick();
      chk("rst_mid_no_pulse1", {11'd0, if8b.out_valid}, 12'd0);
      tick();
      chk("rst_mid_no_pulse2", {11'd0, if8b.out_valid}, 12'd0);
      dir8("after_rst", 8'h12, 8'h34, 1'b1, 12'h847);

      // Random stream: both 8-bit instances against the model, X operands while idle.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      pv1 = 1'b0; pv2 = 1'b0; pr1 = '0; pr2 = '0; hold1 = '0; hold2 = '0;
      accepted = 0; nout1 = 0; nout2 = 0;
      for (int i = 0; i < 1003; i++) begin
         if (pv1) hold1 = pr1;
         if (pv2) hold2 = pr2;
         chk("rnd_p1", obs1, {pv1, hold1});
         chk("rnd_p2", obs2, {pv2, hold2});
         if (if8a.out_valid) nout1++;
         if (if8b.out_valid) nout2++;
         pv2 = pv1;
         pr2 = pr1;
         v = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (v) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            drive8(1'b1, ra, rb, rc);
            pr1 = model8(ra, rb, rc);
            accepted++;
         end else begin
            drive8(1'b0, 8'bx, 8'bx, 1'bx);
         end
         pv1 = v;
         tick();
      end
      chk("rnd_count_p1", 12'(nout1), 12'(accepted));
      chk("rnd_count_p2", 12'(nout2), 12'(accepted));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/adder_n_core.md
Name: adder_n_core

Overview:
- Registered, parameterised ripple/carry adder: sum = a + b + cin, with carry-out and status flags.
- Used as the arithmetic leaf in datapath blocks.
- Consumes one operand set per cycle under a valid qualifier.
- Delivers results after a fixed pipeline latency with a matching valid flag.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 1..64).
- PIPE_STAGES, 1, result latency in clock cycles (legal values 1 or 2). With 2, the add is split at bit WIDTH/2 (rounded down, minimum 1) and the low-half carry is registered into the upper half.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A (unsigned; also read as two's complement for ovf).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result valid this cycle.
- sum  output  WIDTH  low WIDTH bits of a+b+cin.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
- zero  output  1  sum == 0.

Behaviour:
- All state updates on the rising edge of clk. No combinational path from inputs to outputs.
- Reset: while rst=1 at a clock edge:
  - all pipeline registers clear;
  - out_valid=0, sum=0, cout=0, ovf=0, zero=0.
  - Reset mid-operation discards every in-flight result; no out_valid pulse for operands accepted before or during reset.
- Arithmetic:
  - {cout,sum} = a + b + cin, computed at WIDTH+1 bits with no truncation of the carry.
  - ovf and zero are derived from the same final sum.
  - cin=1 with a=b=all-ones gives sum=all-ones, cout=1.
- Latency:
  - operands sampled on the edge where in_valid=1 appear on the outputs exactly PIPE_STAGES edges later, with out_valid=1 for one cycle per accepted operand set.
  - Back-to-back in_valid=1 yields back-to-back results (throughput 1/cycle).
  - No backpressure.
- Idle: when a stage's valid is 0, its data registers hold their previous contents.
  - sum/cout/ovf/zero keep the last result while out_valid=0.
  - Consumers qualify them with out_valid.
- PIPE_STAGES=2:
  - stage 1 registers the low-half sum, low-half carry, upper operand halves and valid;
  - stage 2 adds the upper halves plus the registered carry.
  - Results must be bit-identical to PIPE_STAGES=1.
- Inputs with X on a, b or cin while in_valid=0 must not affect outputs.

Optional Feature:
- Macro: ADDER_N_SAT_EN.
- Defined: unsigned saturation.
  - When the true result exceeds all-ones (cout=1), sum is forced to all-ones.
  - cout still reports 1, so the event stays visible.
  - zero is computed on the saturated sum.
  - ovf is unchanged (computed on the raw sum).
  - Latency unchanged.
- Undefined: sum wraps modulo 2^WIDTH as specified above.

Test Plan:
- WIDTH=8, PIPE_STAGES=1: a=00000011, b=00000101, cin=0, in_valid=1 -> one cycle later sum=00001000, cout=0, ovf=0, zero=0, out_valid=1.
- a=11111111, b=00000001, cin=0 -> sum=00000000, cout=1, zero=1, ovf=0. With ADDER_N_SAT_EN: sum=11111111, cout=1, zero=0.
- a=01111111, b=00000001, cin=0 -> sum=10000000, cout=0, ovf=1. Also a=11111111, b=11111111, cin=1 -> sum=11111111, cout=1.
- Random stream of 1000 operand sets with in_valid toggling randomly, against a reference model:
  - all results match;
  - out_valid count equals accepted count;
  - run for PIPE_STAGES=1 and 2 with identical outputs shifted by one cycle.
- PIPE_STAGES=2:
  - assert in_valid for 2 cycles, then raise rst on the next edge -> out_valid stays 0 and all outputs read 0 after the reset edge;
  - a new operand after reset completes with correct result 2 cycles later.
- WIDTH=1 corner: a=1, b=1, cin=1 -> sum=1, cout=1, ovf=0.
